// File: rtl/bufclr_pkg.sv
// Shared definitions for the buffer-clear encoder: FSM state encoding,
// the two-bit clear codes carried in bit2/bit3 and the frame length.
package bufclr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT2 = 2'd1,
        ST_BIT3 = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // {bit2, bit3} of a frame
    localparam logic [1:0] CODE_EVEN = 2'b10;
    localparam logic [1:0] CODE_ODD  = 2'b01;

    localparam int FRAME_LEN = 4;

    // Code carried by a frame for the selected source
    function automatic logic [1:0] sel_code(input logic odd);
        return odd ? CODE_ODD : CODE_EVEN;
    endfunction

endpackage

// File: rtl/bufclr_pend_cnt.sv
// Saturating pending-clear counter for one source.
// next = count + inc - dec; a pulse arriving while the queue is full and
// nothing is being launched from it is dropped and flagged on ovf.
module bufclr_pend_cnt #(
    parameter int MAXPEND = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       launch,
    output logic [2:0] count,
    output logic       ovf
);

    localparam logic [2:0] MAX_CNT = 3'(MAXPEND);

    logic [2:0] count_q;
    logic [2:0] count_d;
    logic       full;

    // Increment/decrement with overflow detection
    always_comb begin
        full    = (count_q == MAX_CNT);
        ovf     = clr && full && !launch;
        count_d = count_q;
        if (clr && !ovf) begin
            count_d = count_d + 3'd1;
        end
        if (launch) begin
            count_d = count_d - 3'd1;
        end
    end

    // Counter register; pulses coincident with reset are discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/buf_clr_encoder.sv
// Serial UnDoBuf encoder: queues front-end buffer-clear pulses and sends one
// 4-cycle frame (start, bit2, bit3, gap) per queued clear.
// Optional feature macro: BUFCLR_DUAL_EN (second, odd source with
// round-robin arbitration). Undefined: only the even source exists.
//
// state   | meaning
// ST_IDLE | no frame; launches when any clear is pending (start bit next)
// ST_BIT2 | start bit on Stream; bit2 of selected code registered next
// ST_BIT3 | bit2 on Stream; bit3 registered next
// ST_GAP  | bit3 on Stream; gap (0) registered next
module buf_clr_encoder
    import bufclr_pkg::*;
#(
    parameter int MAXPEND = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ClrEven,
    input  logic        ClrOdd,
    output logic        Stream,
    output logic        Busy,
    output logic [2:0]  NPendEven,
    output logic [2:0]  NPendOdd,
    output logic        OvfErr,
    output logic [15:0] NSent
);

    state_e      state_q, state_d;
    logic        stream_q, stream_d;
    logic        sel_odd_q, sel_odd_d;
    logic        last_odd_q, last_odd_d;
    logic        ovf_q, ovf_d;
    logic [15:0] nsent_q, nsent_d;

    logic        launch_even;
    logic        launch_odd;
    logic        pick_odd;
    logic [1:0]  code;
    logic [2:0]  pend_even;
    logic [2:0]  pend_odd;
    logic        ovf_even;
    logic        ovf_odd;

    bufclr_pend_cnt #(.MAXPEND(MAXPEND)) u_pend_even (
        .clock  (Clock),
        .reset  (Reset),
        .clr    (ClrEven),
        .launch (launch_even),
        .count  (pend_even),
        .ovf    (ovf_even)
    );

`ifdef BUFCLR_DUAL_EN
    bufclr_pend_cnt #(.MAXPEND(MAXPEND)) u_pend_odd (
        .clock  (Clock),
        .reset  (Reset),
        .clr    (ClrOdd),
        .launch (launch_odd),
        .count  (pend_odd),
        .ovf    (ovf_odd)
    );
`else
    // Single-source board: odd input has no effect, odd queue is always empty
    logic odd_unused;
    assign odd_unused = ^{ClrOdd, launch_odd};
    assign pend_odd   = 3'd0;
    assign ovf_odd    = 1'b0;
`endif

    // Next-state, source arbitration and serial bit selection
    always_comb begin
        state_d     = state_q;
        stream_d    = 1'b0;
        sel_odd_d   = sel_odd_q;
        last_odd_d  = last_odd_q;
        nsent_d     = nsent_q;
        launch_even = 1'b0;
        launch_odd  = 1'b0;
        pick_odd    = 1'b0;
        code        = sel_code(sel_odd_q);
        ovf_d       = ovf_even | ovf_odd;

        case (state_q)
            ST_IDLE: begin
                if ((pend_even != 3'd0) || (pend_odd != 3'd0)) begin
                    if ((pend_even != 3'd0) && (pend_odd != 3'd0)) begin
                        pick_odd = !last_odd_q;
                    end else begin
                        pick_odd = (pend_odd != 3'd0);
                    end
                    state_d     = ST_BIT2;
                    stream_d    = 1'b1;
                    sel_odd_d   = pick_odd;
                    last_odd_d  = pick_odd;
                    launch_odd  = pick_odd;
                    launch_even = !pick_odd;
                    nsent_d     = nsent_q + 16'd1;
                end
            end
            ST_BIT2: begin
                stream_d = code[1];
                state_d  = ST_BIT3;
            end
            ST_BIT3: begin
                stream_d = code[0];
                state_d  = ST_GAP;
            end
            ST_GAP: begin
                stream_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            stream_q   <= 1'b0;
            sel_odd_q  <= 1'b0;
            last_odd_q <= 1'b0;
            ovf_q      <= 1'b0;
            nsent_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            stream_q   <= stream_d;
            sel_odd_q  <= sel_odd_d;
            last_odd_q <= last_odd_d;
            ovf_q      <= ovf_d;
            nsent_q    <= nsent_d;
        end
    end

    assign Stream    = stream_q;
    assign Busy      = (state_q != ST_IDLE);
    assign NPendEven = pend_even;
    assign NPendOdd  = pend_odd;
    assign OvfErr    = ovf_q;
    assign NSent     = nsent_q;

endmodule
